// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: control inputs, instruction ROM port and IF/ID outputs
interface fetch_stage_if;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        valid;
  logic        fetch_fault;

  modport master (
    input  stall, flush, redirect, redirect_pc, imem_rd,
    output imem_addr, instr, pc, pc_plus4, valid, fetch_fault
  );

  modport slave (
    output stall, flush, redirect, redirect_pc, imem_rd,
    input  imem_addr, instr, pc, pc_plus4, valid, fetch_fault
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RISC-V instruction fetch stage with PC and IF/ID register; optional IFETCH_BOUNDS_CHECK_EN
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
`ifdef IFETCH_BOUNDS_CHECK_EN
  ,
  parameter logic [31:0] ROM_BASE  = 32'hBFC0_0000,
  parameter logic [31:0] ROM_SIZE  = 32'h0000_1000
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    BOOT
  , RUN
`ifdef IFETCH_BOUNDS_CHECK_EN
  , FAULT
`endif
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;
  logic [31:0] target;

  // Redirect targets are always word aligned.
  assign target = {bus.redirect_pc[31:2], 2'b00};

`ifdef IFETCH_BOUNDS_CHECK_EN
  logic fault_q;

  // Subtract-then-compare so a window touching the top of the address space cannot overflow.
  function automatic logic in_window(input logic [31:0] addr);
    return (addr >= ROM_BASE) && ((addr - ROM_BASE) < ROM_SIZE);
  endfunction

  assign bus.fetch_fault = fault_q;
`else
  assign bus.fetch_fault = 1'b0;
`endif

  assign bus.imem_addr = pc_q;
  assign bus.instr     = instr_q;
  assign bus.pc        = pc_out_q;
  assign bus.pc_plus4  = pc_plus4_q;
  assign bus.valid     = valid_q;

  // Fetch FSM: PC sequencing and IF/ID register; priority redirect > flush > stall > fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_out_q   <= 32'h0;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
`ifdef IFETCH_BOUNDS_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (bus.redirect) begin
            pc_q    <= target;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
          end else if (bus.flush) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            if (!bus.stall) pc_q <= pc_q + 32'd4;
          end else if (bus.stall) begin
            pc_q <= pc_q;
`ifdef IFETCH_BOUNDS_CHECK_EN
          end else if (!in_window(pc_q)) begin
            state   <= FAULT;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            fault_q <= 1'b1;
`endif
          end else begin
            instr_q    <= bus.imem_rd;
            pc_out_q   <= pc_q;
            pc_plus4_q <= pc_q + 32'd4;
            valid_q    <= 1'b1;
            pc_q       <= pc_q + 32'd4;
          end
        end
`ifdef IFETCH_BOUNDS_CHECK_EN
        FAULT: begin
          // Only an in-window redirect recovers; PC stays frozen otherwise.
          instr_q <= NOP_INSTR;
          valid_q <= 1'b0;
          if (bus.redirect && in_window(target)) begin
            state   <= RUN;
            pc_q    <= target;
            fault_q <= 1'b0;
          end
        end
`endif
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule
